// File: rtl/hsp_fifo_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hsp_fifo_reader                                               |
// | Purpose  : Read-side controller for the hit summary FIFO; filters null   |
// |            entries and presents hits on a valid/ready interface.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hsp_fifo_reader #(
  parameter int LENGTH_COUNTER = 8,
  parameter int READ_LATENCY   = 1
) (
  input  logic                          array_clk,
  input  logic                          reset,
  input  logic                          drain_en,
  input  logic                          fifo_empty,
  output logic                          read_HSP,
  input  logic [LENGTH_COUNTER-1:0]     hit_add_inQ_UnGap,
  input  logic [LENGTH_COUNTER-1:0]     hit_add_inS_UnGap,
  input  logic [LENGTH_COUNTER-1:0]     hit_length_UnGap,
  output logic                          hit_valid,
  input  logic                          hit_ready,
  output logic [3*LENGTH_COUNTER-1:0]   hit_data,
  output logic [LENGTH_COUNTER-1:0]     hit_count,
  output logic [LENGTH_COUNTER-1:0]     drop_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam int                        WAIT_W    = 3;
  localparam logic [WAIT_W-1:0]         WAIT_INIT = WAIT_W'(READ_LATENCY - 1);
  localparam logic [WAIT_W-1:0]         WAIT_ONE  = WAIT_W'(1);
  localparam logic [LENGTH_COUNTER-1:0] CNT_MAX   = '1;
  localparam logic [LENGTH_COUNTER-1:0] CNT_ONE   = LENGTH_COUNTER'(1);

  state_t                        state_q, state_d;
  logic [WAIT_W-1:0]             wait_cnt_q, wait_cnt_d;
  logic                          read_hsp_q, read_hsp_d;
  logic                          hit_valid_q, hit_valid_d;
  logic [3*LENGTH_COUNTER-1:0]   hit_data_q, hit_data_d;
  logic [LENGTH_COUNTER-1:0]     hit_count_q, hit_count_d;
  logic [LENGTH_COUNTER-1:0]     drop_count_q, drop_count_d;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    read_hsp_d   = 1'b0;
    hit_valid_d  = hit_valid_q;
    hit_data_d   = hit_data_q;
    hit_count_d  = hit_count_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_IDLE: begin
        // The strobe is raised on entry to READ so it is a plain flop output.
        if (drain_en && !fifo_empty) begin
          state_d    = ST_READ;
          read_hsp_d = 1'b1;
        end
      end
      ST_READ: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_ONE;
        if (wait_cnt_q == WAIT_ONE) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (hit_length_UnGap != '0) begin
          hit_data_d  = {hit_add_inQ_UnGap, hit_add_inS_UnGap, hit_length_UnGap};
          hit_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          if (drop_count_q != CNT_MAX) begin
            drop_count_d = drop_count_q + CNT_ONE;
          end
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hit_ready) begin
          hit_valid_d = 1'b0;
          if (hit_count_q != CNT_MAX) begin
            hit_count_d = hit_count_q + CNT_ONE;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge array_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      read_hsp_q   <= 1'b0;
      hit_valid_q  <= 1'b0;
      hit_data_q   <= '0;
      hit_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      read_hsp_q   <= read_hsp_d;
      hit_valid_q  <= hit_valid_d;
      hit_data_q   <= hit_data_d;
      hit_count_q  <= hit_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign read_HSP   = read_hsp_q;
  assign hit_valid  = hit_valid_q;
  assign hit_data   = hit_data_q;
  assign hit_count  = hit_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hsp_fifo_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hsp_fifo_reader                                            |
// | Purpose  : Self-checking bench for hsp_fifo_reader, latency 1 and 3.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_hsp_fifo_reader;

  logic        clk;
  logic        reset;
  logic        drain_en_a, drain_en_b;
  logic        fifo_empty_a, fifo_empty_b;
  logic        read_a, read_b;
  logic [23:0] data_a, data_b;
  logic        hit_valid_a, hit_valid_b;
  logic        hit_ready_a, hit_ready_b;
  logic [23:0] hit_data_a, hit_data_b;
  logic [7:0]  hit_count_a, hit_count_b;
  logic [7:0]  drop_count_a, drop_count_b;

  hsp_fifo_reader #(.LENGTH_COUNTER(8), .READ_LATENCY(1)) u_dut_a (
    .array_clk         (clk),
    .reset             (reset),
    .drain_en          (drain_en_a),
    .fifo_empty        (fifo_empty_a),
    .read_HSP          (read_a),
    .hit_add_inQ_UnGap (data_a[23:16]),
    .hit_add_inS_UnGap (data_a[15:8]),
    .hit_length_UnGap  (data_a[7:0]),
    .hit_valid         (hit_valid_a),
    .hit_ready         (hit_ready_a),
    .hit_data          (hit_data_a),
    .hit_count         (hit_count_a),
    .drop_count        (drop_count_a)
  );

  hsp_fifo_reader #(.LENGTH_COUNTER(8), .READ_LATENCY(3)) u_dut_b (
    .array_clk         (clk),
    .reset             (reset),
    .drain_en          (drain_en_b),
    .fifo_empty        (fifo_empty_b),
    .read_HSP          (read_b),
    .hit_add_inQ_UnGap (data_b[23:16]),
    .hit_add_inS_UnGap (data_b[15:8]),
    .hit_length_UnGap  (data_b[7:0]),
    .hit_valid         (hit_valid_b),
    .hit_ready         (hit_ready_b),
    .hit_data          (hit_data_b),
    .hit_count         (hit_count_b),
    .drop_count        (drop_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          reads_a = 0;
  int          reads_b = 0;
  logic [23:0] fq_a[$], fq_b[$];
  logic [23:0] exp_a[$], exp_b[$];
  logic [23:0] pipe_a[8], pipe_b[8];
  logic [7:0]  exp_hc_a, exp_hc_b, exp_dc_a, exp_dc_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [23:0] e);
    fq_a.push_back(e);
    fifo_empty_a = 1'b0;
  endtask

  task automatic push_b(input logic [23:0] e);
    fq_b.push_back(e);
    fifo_empty_b = 1'b0;
  endtask

  // Scoreboard half runs before the edge (valid/ready as the DUT will see them);
  // the FIFO model runs at the negedge and presents data READ_LATENCY cycles on.
  task automatic tick();
    logic [23:0] e;
    if (reset) begin
      exp_a.delete(); exp_b.delete();
      exp_hc_a = 8'h00; exp_hc_b = 8'h00; exp_dc_a = 8'h00; exp_dc_b = 8'h00;
    end else begin
      if (hit_valid_a && hit_ready_a) begin
        e = 24'h0;
        if (exp_a.size() != 0) e = exp_a.pop_front();
        chk("sb_a_data", 32'(hit_data_a), 32'(e));
        if (exp_hc_a != 8'hFF) exp_hc_a++;
      end
      if (hit_valid_b && hit_ready_b) begin
        e = 24'h0;
        if (exp_b.size() != 0) e = exp_b.pop_front();
        chk("sb_b_data", 32'(hit_data_b), 32'(e));
        if (exp_hc_b != 8'hFF) exp_hc_b++;
      end
    end
    @(negedge clk);
    cyc++;
    for (int k = 7; k > 0; k--) begin
      pipe_a[k] = pipe_a[k-1];
      pipe_b[k] = pipe_b[k-1];
    end
    pipe_a[0] = 24'h0;
    pipe_b[0] = 24'h0;
    if (read_a) begin
      reads_a++;
      chk("a_read_nonempty", 32'(fq_a.size() != 0), 32'd1);
      if (fq_a.size() != 0) begin
        e = fq_a.pop_front();
        pipe_a[0] = e;
        if (e[7:0] != 8'h00) exp_a.push_back(e);
        else if (exp_dc_a != 8'hFF) exp_dc_a++;
      end
    end
    if (read_b) begin
      reads_b++;
      chk("b_read_nonempty", 32'(fq_b.size() != 0), 32'd1);
      if (fq_b.size() != 0) begin
        e = fq_b.pop_front();
        pipe_b[0] = e;
        if (e[7:0] != 8'h00) exp_b.push_back(e);
        else if (exp_dc_b != 8'hFF) exp_dc_b++;
      end
    end
    data_a       = pipe_a[1];
    data_b       = pipe_b[3];
    fifo_empty_a = (fq_a.size() == 0);
    fifo_empty_b = (fq_b.size() == 0);
  endtask

  initial begin
    int          k, c1, r0, bad, saw_valid;
    logic [23:0] d0;
    reset = 1'b1;
    drain_en_a = 1'b1; drain_en_b = 1'b0;
    hit_ready_a = 1'b1; hit_ready_b = 1'b1;
    fifo_empty_a = 1'b1; fifo_empty_b = 1'b1;
    data_a = 24'h0; data_b = 24'h0;
    exp_hc_a = 8'h00; exp_hc_b = 8'h00; exp_dc_a = 8'h00; exp_dc_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pipe_a[i] = 24'h0;
      pipe_b[i] = 24'h0;
    end

    // 1: reset held with work pending
    push_a(24'h251003);
    repeat (3) begin
      tick();
      chk("t1_read", 32'(read_a), 32'd0);
      chk("t1_valid", 32'(hit_valid_a), 32'd0);
      chk("t1_hitcnt", 32'(hit_count_a), 32'd0);
      chk("t1_dropcnt", 32'(drop_count_a), 32'd0);
    end
    chk("t1_data", 32'(hit_data_a), 32'd0);
    reset = 1'b0;

    // 2: single hit, latency 1
    k = 0;
    while (!read_a && k < 10) begin tick(); k++; end
    chk("t2_read_seen", 32'(read_a), 32'd1);
    tick();
    chk("t2_read_one_cycle", 32'(read_a), 32'd0);
    chk("t2_valid_early", 32'(hit_valid_a), 32'd0);
    tick();
    chk("t2_valid", 32'(hit_valid_a), 32'd1);
    chk("t2_data", 32'(hit_data_a), 32'h251003);
    tick();
    chk("t2_valid_drop", 32'(hit_valid_a), 32'd0);
    chk("t2_hitcnt", 32'(hit_count_a), 32'd1);

    // 3: null entry followed by a hit
    push_a(24'h112200);
    push_a(24'h334405);
    k = 0;
    while (!read_a && k < 10) begin tick(); k++; end
    chk("t3_read_seen", 32'(read_a), 32'd1);
    c1 = cyc;
    saw_valid = 0;
    tick();
    k = 0;
    while (!read_a && k < 20) begin
      if (hit_valid_a) saw_valid = 1;
      tick();
      k++;
    end
    chk("t3_no_valid", 32'(saw_valid), 32'd0);
    chk("t3_spacing", 32'(cyc - c1), 32'd3);
    chk("t3_dropcnt", 32'(drop_count_a), 32'd1);
    k = 0;
    while (hit_count_a != 8'd2 && k < 20) begin tick(); k++; end
    chk("t3_hitcnt", 32'(hit_count_a), 32'd2);

    // 4: backpressure
    hit_ready_a = 1'b0;
    push_a(24'h556607);
    push_a(24'h778809);
    k = 0;
    while (!hit_valid_a && k < 20) begin tick(); k++; end
    chk("t4_valid", 32'(hit_valid_a), 32'd1);
    d0 = hit_data_a;
    chk("t4_data", 32'(d0), 32'h556607);
    r0 = reads_a;
    bad = 0;
    repeat (10) begin
      tick();
      if (!hit_valid_a || hit_data_a !== d0) bad++;
    end
    chk("t4_stable", 32'(bad), 32'd0);
    chk("t4_no_read", 32'(reads_a - r0), 32'd0);
    hit_ready_a = 1'b1;
    tick();
    chk("t4_one_xfer", 32'(hit_valid_a), 32'd0);
    chk("t4_hitcnt_step", 32'(hit_count_a), 32'd3);
    k = 0;
    while (hit_count_a != 8'd4 && k < 30) begin tick(); k++; end
    chk("t4_hitcnt", 32'(hit_count_a), 32'(exp_hc_a));
    chk("t4_sb_empty", 32'(exp_a.size()), 32'd0);

    // 5: drain stop during WAIT, latency 3
    push_b(24'hA1B2C3);
    push_b(24'hD4E5F6);
    drain_en_b = 1'b1;
    k = 0;
    while (!read_b && k < 10) begin tick(); k++; end
    chk("t5_read_seen", 32'(read_b), 32'd1);
    c1 = cyc;
    tick();
    drain_en_b = 1'b0;
    k = 0;
    while (!hit_valid_b && k < 20) begin tick(); k++; end
    chk("t5_latency", 32'(cyc - c1), 32'd4);
    chk("t5_data", 32'(hit_data_b), 32'hA1B2C3);
    r0 = reads_b;
    repeat (20) tick();
    chk("t5_no_read", 32'(reads_b - r0), 32'd0);
    chk("t5_hitcnt", 32'(hit_count_b), 32'd1);
    drain_en_b = 1'b1;
    k = 0;
    while (hit_count_b != 8'd2 && k < 30) begin tick(); k++; end
    chk("t5_resume", 32'(hit_count_b), 32'(exp_hc_b));
    chk("t5_dropcnt", 32'(drop_count_b), 32'd0);

    // 6: saturation, then reset while holding a hit
    for (int i = 0; i < 300; i++) begin
      push_a({8'(i), ~8'(i), 8'((i % 255) + 1)});
    end
    k = 0;
    while ((fq_a.size() != 0 || exp_a.size() != 0) && k < 3000) begin tick(); k++; end
    chk("t6_drained", 32'(exp_a.size() + fq_a.size()), 32'd0);
    chk("t6_hitcnt_model", 32'(hit_count_a), 32'(exp_hc_a));
    chk("t6_hitcnt_sat", 32'(hit_count_a), 32'hFF);
    chk("t6_dropcnt", 32'(drop_count_a), 32'd1);
    hit_ready_a = 1'b0;
    push_a(24'h99AABB);
    k = 0;
    while (!hit_valid_a && k < 20) begin tick(); k++; end
    chk("t6_hold", 32'(hit_valid_a), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(hit_valid_a), 32'd0);
    chk("t6_rst_hitcnt", 32'(hit_count_a), 32'd0);
    chk("t6_rst_dropcnt", 32'(drop_count_a), 32'd0);
    chk("t6_rst_data", 32'(hit_data_a), 32'd0);
    reset = 1'b0;
    hit_ready_a = 1'b1;
    r0 = reads_a;
    repeat (5) tick();
    chk("t6_idle_after", 32'(reads_a - r0), 32'd0);
    chk("t6_valid_after", 32'(hit_valid_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
